// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
// The FREQ_* defaults only matter when PLL_FREQ_CHECK_EN is defined.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_state_e;

    localparam int unsigned FREQ_WINDOW_DEF = 100000;
    localparam int unsigned FREQ_EXPECT_DEF = 1000;
    localparam int unsigned FREQ_TOL_DEF    = 2;

    // Bits needed to hold any value in 0..max_val; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 1);
        return (w == 0) ? 1 : w;
    endfunction

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_freq_meter.sv
// pll_freq_meter: counts rising edges of the slow PLL output per refclk window while in RUN.
// Only compiled when PLL_FREQ_CHECK_EN is defined, so the default build carries no meter.
`ifdef PLL_FREQ_CHECK_EN
module pll_freq_meter
    import pll_seq_pkg::*;
#(
    parameter int unsigned WINDOW = FREQ_WINDOW_DEF,
    parameter int unsigned EXPECT = FREQ_EXPECT_DEF,
    parameter int unsigned TOL    = FREQ_TOL_DEF
) (
    input  logic clk,
    input  logic srst,
    input  logic run_i,
    input  logic mon_clk_i,
    output logic bad_o
);

    localparam int unsigned WW = cnt_width(WINDOW);
    localparam int unsigned LO = (EXPECT > TOL) ? (EXPECT - TOL) : 0;
    localparam int unsigned HI = EXPECT + TOL;

    logic [1:0]    mon_sync_q;
    logic          mon_prev_q;
    logic [WW-1:0] win_q, win_d;
    logic [WW-1:0] edges_q, edges_d;
    logic          rise;
    logic          win_end;
    logic [WW-1:0] edges_total;

    assign rise        = mon_sync_q[1] & ~mon_prev_q;
    assign win_end     = run_i && (win_q == WW'(WINDOW - 1));
    // Edges can never exceed the window length, so WW bits always suffice.
    assign edges_total = edges_q + WW'(rise);
    assign bad_o       = win_end && ((32'(edges_total) < LO) || (32'(edges_total) > HI));

    always_comb begin
        win_d   = win_q + 1'b1;
        edges_d = edges_total;
        if (!run_i || win_end) begin
            win_d   = '0;
            edges_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            mon_sync_q <= '0;
            mon_prev_q <= 1'b0;
            win_q      <= '0;
            edges_q    <= '0;
        end else begin
            mon_sync_q <= {mon_sync_q[0], mon_clk_i};
            mon_prev_q <= mon_sync_q[1];
            win_q      <= win_d;
            edges_q    <= edges_d;
        end
    end

endmodule
`endif

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock supervisor: pulses pll_rst, qualifies lock, then releases sys_rst.
// Define PLL_FREQ_CHECK_EN to add mon_clk frequency supervision while in RUN.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 100000,
    parameter int unsigned STABLE_CYCLES       = 1024,
    parameter int unsigned MAX_RETRIES         = 4,
    parameter int unsigned FREQ_WINDOW         = FREQ_WINDOW_DEF,
    parameter int unsigned FREQ_EXPECT         = FREQ_EXPECT_DEF,
    parameter int unsigned FREQ_TOL            = FREQ_TOL_DEF
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       mon_clk,
    input  logic       retry_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       pll_ready,
    output logic       fault,
    output logic [2:0] retry_count,
    output logic [7:0] lock_loss_count,
    output logic       freq_err
);

    localparam int unsigned CNT_MAX = max3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES);
    localparam int unsigned CW      = cnt_width(CNT_MAX);

    logic [1:0]    lock_sync_q;
    logic          locked_s;
    pll_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    retry_q, retry_d;
    logic [7:0]    llc_q, llc_d;
    logic          pll_rst_q, sys_rst_q, pll_ready_q, fault_q;
    logic          in_run;
    logic          freq_bad;

    assign locked_s = lock_sync_q[1];
    assign in_run   = (state_q == RUN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        llc_d   = llc_q;
        case (state_q)
            RESET_PLL: begin
                if (cnt_q == CW'(RST_PULSE_CYCLES - 1)) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_LOCK: begin
                // A lock seen in the timeout cycle takes priority over the retry.
                if (locked_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
                    retry_d = retry_q + 3'd1;
                    cnt_d   = '0;
                    state_d = (retry_d == 3'(MAX_RETRIES)) ? FAULT : RESET_PLL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (!locked_s || freq_bad) begin
                    state_d = RESET_PLL;
                    cnt_d   = '0;
                    retry_d = '0;
                    if (llc_q != 8'hFF) begin
                        llc_d = llc_q + 8'd1;
                    end
                end
            end
            FAULT: begin
                if (retry_req) begin
                    state_d = RESET_PLL;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = RESET_PLL;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they align with the state register.
    always_ff @(posedge refclk) begin
        if (rst) begin
            lock_sync_q <= '0;
            state_q     <= RESET_PLL;
            cnt_q       <= '0;
            retry_q     <= '0;
            llc_q       <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            pll_ready_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            lock_sync_q <= {lock_sync_q[0], pll_locked};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            llc_q       <= llc_d;
            pll_rst_q   <= (state_d == RESET_PLL) || (state_d == FAULT);
            sys_rst_q   <= (state_d != RUN);
            pll_ready_q <= (state_d == RUN);
            fault_q     <= (state_d == FAULT);
        end
    end

    assign pll_rst         = pll_rst_q;
    assign sys_rst         = sys_rst_q;
    assign pll_ready       = pll_ready_q;
    assign fault           = fault_q;
    assign retry_count     = retry_q;
    assign lock_loss_count = llc_q;

`ifdef PLL_FREQ_CHECK_EN
    logic freq_err_q, freq_err_d;

    pll_freq_meter #(
        .WINDOW (FREQ_WINDOW),
        .EXPECT (FREQ_EXPECT),
        .TOL    (FREQ_TOL)
    ) u_freq_meter (
        .clk       (refclk),
        .srst      (rst),
        .run_i     (in_run),
        .mon_clk_i (mon_clk),
        .bad_o     (freq_bad)
    );

    always_comb begin
        freq_err_d = freq_err_q;
        if (freq_bad) begin
            freq_err_d = 1'b1;
        end else if (retry_req) begin
            freq_err_d = 1'b0;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            freq_err_q <= 1'b0;
        end else begin
            freq_err_q <= freq_err_d;
        end
    end

    assign freq_err = freq_err_q;
`else
    logic freq_unused;

    assign freq_bad    = 1'b0;
    assign freq_err    = 1'b0;
    assign freq_unused = mon_clk ^ in_run ^ (FREQ_WINDOW == 0) ^ (FREQ_EXPECT == 0) ^ (FREQ_TOL == 0);
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: stimulus pushes the expected output vector and
// the cycle it must appear in; the monitor pops one entry on every observed output change.
module tb_pll_reset_sequencer;

    typedef struct packed {
        logic       pll_rst;
        logic       sys_rst;
        logic       pll_ready;
        logic       fault;
        logic [2:0] retry;
        logic [7:0] llc;
        logic       ferr;
    } obs_t;

    typedef struct packed {
        logic [31:0] cyc;
        obs_t        v;
    } exp_t;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       mon_clk = 1'b0;
    logic       retry_req = 1'b0;
    logic       pll_rst, sys_rst, pll_ready, fault, freq_err;
    logic [2:0] retry_count;
    logic [7:0] lock_loss_count;

    int    cyc = 0;
    int    n_vec = 0;
    int    n_bad = 0;
    int    mon_period = 0;
    int    mon_ph = 0;
    bit    armed = 1'b0;
    bit    first_obs = 1'b1;
    obs_t  prev_obs;
    obs_t  cur_obs;
    obs_t  m;
    exp_t  e;
    exp_t  sb_q[$];
    string tag_q[$];
    string tag;

    pll_reset_sequencer #(
        .RST_PULSE_CYCLES    (4),
        .LOCK_TIMEOUT_CYCLES (50),
        .STABLE_CYCLES       (8),
        .MAX_RETRIES         (2),
        .FREQ_WINDOW         (200),
        .FREQ_EXPECT         (10),
        .FREQ_TOL            (1)
    ) dut (
        .refclk          (refclk),
        .rst             (rst),
        .pll_locked      (pll_locked),
        .mon_clk         (mon_clk),
        .retry_req       (retry_req),
        .pll_rst         (pll_rst),
        .sys_rst         (sys_rst),
        .pll_ready       (pll_ready),
        .fault           (fault),
        .retry_count     (retry_count),
        .lock_loss_count (lock_loss_count),
        .freq_err        (freq_err)
    );

    always #5 refclk = ~refclk;

    always @(posedge refclk) cyc <= cyc + 1;

    // Slow monitored clock: high for period/2 refclk cycles, then low.
    initial begin
        forever begin
            @(posedge refclk);
            #1;
            if (mon_period == 0) begin
                mon_clk = 1'b0;
                mon_ph  = 0;
            end else begin
                mon_clk = (mon_ph < mon_period / 2);
                mon_ph  = (mon_ph + 1) % mon_period;
            end
        end
    end

    always @(negedge refclk) begin
        if (armed) begin
            cur_obs = {pll_rst, sys_rst, pll_ready, fault, retry_count, lock_loss_count, freq_err};
            if (first_obs || (cur_obs !== prev_obs)) begin
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_change got cyc=%0d out=%h, no change expected", cyc, cur_obs);
                end else begin
                    e   = sb_q.pop_front();
                    tag = tag_q.pop_front();
                    if ((e.cyc != 32'(cyc)) || (e.v !== cur_obs)) begin
                        n_bad++;
                        $display("FAIL %s got cyc=%0d out=%h want cyc=%0d out=%h",
                                 tag, cyc, cur_obs, e.cyc, e.v);
                    end else begin
                        $display("vec %s cyc=%0d out=%h", tag, cyc, cur_obs);
                    end
                end
            end
            prev_obs  = cur_obs;
            first_obs = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got cyc=%0d, want finish before 40000 cycles", cyc);
        $fatal(1, "watchdog");
    end

    task automatic go(input int n);
        while (cyc < n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic expect_at(input int c, input string t);
        sb_q.push_back({32'(c), m});
        tag_q.push_back(t);
    endtask

    task automatic m_reset();
        m = '{pll_rst: 1'b1, sys_rst: 1'b1, pll_ready: 1'b0, fault: 1'b0,
              retry: 3'd0, llc: 8'd0, ferr: 1'b0};
    endtask

    task automatic m_loss();
        m.pll_rst   = 1'b1;
        m.sys_rst   = 1'b1;
        m.pll_ready = 1'b0;
        m.retry     = 3'd0;
        if (m.llc != 8'hFF) m.llc = m.llc + 8'd1;
    endtask

    task automatic m_wait();
        m.pll_rst = 1'b0;
    endtask

    task automatic m_run();
        m.pll_rst   = 1'b0;
        m.sys_rst   = 1'b0;
        m.pll_ready = 1'b1;
    endtask

    initial begin
        // Power-up, lock from cycle 10 after release.
        go(3);
        m_reset();
        expect_at(3, "reset_state");
        armed = 1'b1;
        rst   = 1'b0;
        m_wait();
        expect_at(7, "pll_rst_pulse_end");
        go(13);
        pll_locked = 1'b1;
        m_run();
        expect_at(24, "first_release");

        // Lock loss, then a lock drop part way through qualification.
        go(30);
        pll_locked = 1'b0;
        m_loss();
        expect_at(33, "loss_to_reset_pll");
        m_wait();
        expect_at(37, "wait_lock_entry");
        go(40);
        pll_locked = 1'b1;
        go(45);
        pll_locked = 1'b0;
        go(46);
        pll_locked = 1'b1;
        m_run();
        expect_at(57, "requalified_release");

        // One-cycle lock glitches in RUN, enough to saturate the loss counter.
        for (int i = 0; i < 256; i++) begin
            go(70 + 20 * i);
            pll_locked = 1'b0;
            go(71 + 20 * i);
            pll_locked = 1'b1;
            m_loss();
            expect_at(73 + 20 * i, "glitch_loss");
            m_wait();
            expect_at(77 + 20 * i, "glitch_wait_lock");
            m_run();
            expect_at(86 + 20 * i, "glitch_rerun");
        end

        // No lock: two timeouts lead to FAULT, retry_req recovers.
        go(5200);
        mon_period = 20;
        pll_locked = 1'b0;
        m_loss();
        expect_at(5203, "loss_saturated");
        m_wait();
        expect_at(5207, "wait_lock_a");
        m.retry   = 3'd1;
        m.pll_rst = 1'b1;
        expect_at(5257, "timeout_1");
        m_wait();
        expect_at(5261, "wait_lock_b");
        m.retry   = 3'd2;
        m.pll_rst = 1'b1;
        m.fault   = 1'b1;
        expect_at(5311, "timeout_2_fault");
        go(5320);
        retry_req = 1'b1;
        go(5321);
        retry_req  = 1'b0;
        pll_locked = 1'b1;
        m.fault = 1'b0;
        m.retry = 3'd0;
        expect_at(5321, "retry_req_leaves_fault");
        m_wait();
        expect_at(5325, "wait_lock_c");
        m_run();
        expect_at(5334, "release_after_fault");

        // Frequency supervision: in-tolerance windows, then a fast mon_clk after a fresh RUN entry.
        go(5784);
        pll_locked = 1'b0;
        mon_period = 15;
        go(5785);
        pll_locked = 1'b1;
        m_loss();
        expect_at(5787, "loss_before_freq");
        m_wait();
        expect_at(5791, "wait_lock_d");
        m_run();
        expect_at(5800, "release_before_freq");
`ifdef PLL_FREQ_CHECK_EN
        m_loss();
        m.ferr = 1'b1;
        expect_at(6000, "freq_error");
        m_wait();
        expect_at(6004, "wait_lock_freq");
        m_run();
        expect_at(6013, "release_after_freq");
`endif
        go(6020);
        retry_req = 1'b1;
        go(6021);
        retry_req = 1'b0;
`ifdef PLL_FREQ_CHECK_EN
        m.ferr = 1'b0;
        expect_at(6021, "freq_err_cleared");
`endif

        // Reset while in RUN.
        go(6030);
        mon_period = 0;
        rst = 1'b1;
        go(6031);
        rst = 1'b0;
        m_reset();
        expect_at(6031, "rst_in_run");
        m_wait();
        expect_at(6035, "wait_lock_e");
        m_run();
        expect_at(6044, "release_after_rst");

        // Reset while in WAIT_LOCK.
        go(6060);
        pll_locked = 1'b0;
        m_loss();
        expect_at(6063, "loss_after_rst");
        m_wait();
        expect_at(6067, "wait_lock_f");
        go(6080);
        rst = 1'b1;
        go(6081);
        rst = 1'b0;
        m_reset();
        expect_at(6081, "rst_in_wait_lock");
        m_wait();
        expect_at(6085, "wait_lock_g");

        go(6110);
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            tag = tag_q.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL %s got no change, want cyc=%0d out=%h", tag, e.cyc, e.v);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
